fifo_stream_out: RTL and testbench



---
 rtl/memio_pkg.sv | 17 +
 rtl/fifo_stream_out.sv | 101 ++++++++++
 tb/tb_fifo_stream_out.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memio_pkg.sv
// memio_pkg: constants and types shared by the stream adapters that sit on
// either side of the asynchronous FIFO.
//   STREAM_SKID_DEPTH - words the read-side prefetch buffer can hold
//   OCC_W             - width of an occupancy count covering 0..STREAM_SKID_DEPTH
//   stream_t          - {valid, data} handshake bundle for the upstream writer stage
package memio_pkg;

  localparam int STREAM_SKID_DEPTH = 2;
  localparam int OCC_W             = 2;
  localparam int STREAM_DATA_W     = 8;

  typedef struct packed {
    logic                     valid;
    logic [STREAM_DATA_W-1:0] data;
  } stream_t;

endpackage : memio_pkg

// File: rtl/fifo_stream_out.sv
// fifo_stream_out: read-side adapter for the asynchronous FIFO (deq_clock domain).
// Turns the FIFO's registered-read port (request now, data next cycle) into a
// first-word-fall-through valid/ready stream. It prefetches into a two-entry
// buffer and sustains one word per cycle.
// Ports:
//   clock         FIFO deq_clock, rising edge
//   reset         synchronous, active-high (shared with the FIFO)
//   fifo_empty    FIFO empty flag for the current cycle
//   fifo_data     FIFO read data, valid the cycle after an accepted dequeue
//   fifo_dequeue  dequeue request to the FIFO
//   out_valid     out_data holds a word
//   out_ready     consumer takes the word this cycle
//   out_data      head word of the buffer
//   level         words held in the buffer (0..2), not counting the in-flight word
module fifo_stream_out
  import memio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_dequeue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] level
);

  localparam logic [OCC_W:0] SKID_DEPTH = (OCC_W + 1)'(STREAM_SKID_DEPTH);

  logic [WIDTH-1:0] buf_mem [STREAM_SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             inflight;

  logic             issue;
  logic             pop;
  logic [OCC_W:0]   credit_used;

  // A word is committed to the buffer one cycle after its dequeue, so the
  // request is gated on slots already used plus the word still in flight,
  // minus the slot freed by a pop this cycle. This keeps occ at 2 or less.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    credit_used  = '0;
    fifo_dequeue = 1'b0;
    credit_used  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    if (!reset && !fifo_empty && (credit_used < SKID_DEPTH)) begin
      fifo_dequeue = 1'b1;
    end
  end

  assign issue = fifo_dequeue && !fifo_empty;
  assign pop   = out_valid && out_ready;

  // The outputs are forced to zero while reset is high. This makes the
  // cleared state visible in the same cycle that reset rises, instead of
  // one edge later.
  assign out_valid = !reset && (occ != '0);
  assign out_data  = reset ? '0 : buf_mem[rd_ptr];
  assign level     = reset ? '0 : occ;

  // NOTE: all state, including the two buffer words, uses non-blocking
  // assignments. The buffer is cleared on reset because its head word is
  // visible on out_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ      <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      for (int i = 0; i < STREAM_SKID_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= issue;

      // fifo_data is valid only in the cycle after an accepted dequeue.
      if (inflight) begin
        buf_mem[wr_ptr] <= fifo_data;
        wr_ptr          <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      // A capture and a pop in the same cycle leave occ unchanged.
      case ({inflight, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule : fifo_stream_out

// File: tb/tb_fifo_stream_out.sv
// tb_fifo_stream_out: self-checking bench for fifo_stream_out.
// The FIFO is modelled as a queue with a registered read port. Expected
// output order is the order in which words leave that queue. A monitor
// checks the invariants every cycle, and each task checks its own scenario.
module tb_fifo_stream_out;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_dequeue;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] fifo_q[$];     // words held by the modelled FIFO
  logic [WIDTH-1:0] push_q[$];     // words written by the tasks, enter FIFO next edge
  logic [WIDTH-1:0] exp_q[$];      // words dequeued but not yet delivered
  logic [WIDTH-1:0] delivered[$];  // words accepted by the consumer
  logic             issue_pending = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  fifo_stream_out #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_dequeue (fifo_dequeue),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level)
  );

  always #5 clock = ~clock;

  // FIFO model: registered read, with garbage on fifo_data when no read was taken.
  always @(posedge clock) begin
    logic [WIDTH-1:0] w;
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      fifo_data <= WIDTH'($urandom);
    end else if (issue_pending) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      fifo_data <= w;
    end else begin
      fifo_data <= WIDTH'($urandom);
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Per-cycle monitor, sampled mid-cycle once the inputs have settled.
  always @(negedge clock) begin
    #2;
    issue_pending = fifo_dequeue && !fifo_empty;
    if (reset) begin
      n_checks++;
      if ({fifo_dequeue, out_valid, level, out_data} !== '0)
        $display("FAIL in_reset: deq=%b valid=%b level=%0d data=%h, required all 0",
                 fifo_dequeue, out_valid, level, out_data);
      else n_pass++;
      prev_stall = 1'b0;
    end else begin
      n_checks++;
      if ((fifo_dequeue && fifo_empty) || level > 2 || out_valid !== (level != 0))
        $display("FAIL invariant: deq=%b empty=%b valid=%b level=%0d, required no deq when empty, level<=2, valid==(level!=0)",
                 fifo_dequeue, fifo_empty, out_valid, level);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, prev_data})
          $display("FAIL stall_stable: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, prev_data);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        delivered.push_back(out_data);
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL order: delivered %h, required no word (none dequeued)", out_data);
        else if (out_data !== exp_q[0])
          $display("FAIL order: delivered %h, required %h", out_data, exp_q[0]);
        else n_pass++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic push(input logic [WIDTH-1:0] w);
    push_q.push_back(w);
  endtask

  task automatic check_delivered(input string name, input logic [WIDTH-1:0] exp[$]);
    n_checks++;
    if (delivered.size() != exp.size())
      $display("FAIL %s_count: got %0d words, required %0d", name, delivered.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size() && i < delivered.size(); i++) begin
      n_checks++;
      if (delivered[i] !== exp[i])
        $display("FAIL %s_word%0d: got %h, required %h", name, i, delivered[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      n_checks++;
      if ({fifo_dequeue, out_valid, level, out_data} !== '0)
        $display("FAIL idle_cycle%0d: deq=%b valid=%b level=%0d data=%h, required all 0",
                 i, fifo_dequeue, out_valid, level, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    logic             exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] exp_d [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    logic [WIDTH-1:0] exp[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit found = 0;
    delivered.delete();
    @(negedge clock);
    out_ready = 1'b1;
    foreach (exp[i]) push(exp[i]);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock); #1;
      if (fifo_dequeue) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL lat_first_deq: no dequeue within 10 cycles, required one");
    else n_pass++;
    for (int k = 1; k < 7; k++) begin
      @(negedge clock); #1;
      n_checks++;
      if (out_valid !== exp_v[k] || (exp_v[k] && out_data !== exp_d[k]))
        $display("FAIL lat_cycle%0d: valid=%b data=%h, required valid=%b data=%h",
                 k, out_valid, out_data, exp_v[k], exp_d[k]);
      else n_pass++;
    end
    check_delivered("lat", exp);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int issues = 0;
    delivered.delete();
    @(negedge clock);
    out_ready = 1'b0;
    foreach (exp[i]) push(exp[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #1;
      if (fifo_dequeue && !fifo_empty) issues++;
    end
    n_checks++;
    if (issues != 2) $display("FAIL bp_issues: got %0d dequeues, required 2", issues);
    else n_pass++;
    n_checks++;
    if ({fifo_dequeue, out_valid, level, out_data} !== {1'b0, 1'b1, 2'd2, 8'h11})
      $display("FAIL bp_hold: deq=%b valid=%b level=%0d data=%h, required deq=0 valid=1 level=2 data=11",
               fifo_dequeue, out_valid, level, out_data);
    else n_pass++;
    @(negedge clock);
    out_ready = 1'b1;
    repeat (10) @(negedge clock);
    check_delivered("bp", exp);
  endtask

  task automatic test_toggle_ready();
    logic [WIDTH-1:0] exp[$];
    delivered.delete();
    for (int i = 1; i <= 8; i++) exp.push_back(WIDTH'(i));
    @(negedge clock);
    foreach (exp[i]) push(exp[i]);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      out_ready = (i % 2 == 0);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check_delivered("toggle", exp);
  endtask

  task automatic test_single_word();
    logic [WIDTH-1:0] exp[$] = '{8'h5A};
    int issues = 0;
    delivered.delete();
    @(negedge clock);
    out_ready = 1'b1;
    push(8'h5A);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #1;
      if (fifo_dequeue && !fifo_empty) issues++;
    end
    n_checks++;
    if (issues != 1) $display("FAIL single_issues: got %0d dequeues, required 1", issues);
    else n_pass++;
    n_checks++;
    if ({fifo_dequeue, level} !== 3'b000)
      $display("FAIL single_idle: deq=%b level=%0d, required deq=0 level=0", fifo_dequeue, level);
    else n_pass++;
    check_delivered("single", exp);
  endtask

  task automatic test_reset_midstream();
    logic [WIDTH-1:0] exp[$] = '{8'h77};
    bit full = 0;
    delivered.delete();
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(WIDTH'(8'hA1 + i));
    for (int i = 0; i < 10 && !full; i++) begin
      @(negedge clock); #1;
      if (level == 2) full = 1;
    end
    n_checks++;
    if (!full) $display("FAIL rst_fill: level=%0d after 10 cycles, required 2", level);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, level} !== 3'b000)
      $display("FAIL rst_after: valid=%b level=%0d, required valid=0 level=0", out_valid, level);
    else n_pass++;
    out_ready = 1'b1;
    push(8'h77);
    repeat (6) @(negedge clock);
    check_delivered("rst_first", exp);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] sent[$];
    logic [WIDTH-1:0] w;
    delivered.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        w = WIDTH'($urandom);
        sent.push_back(w);
        push(w);
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !(delivered.size() == sent.size() && level == 0); i++)
      @(negedge clock);
    check_delivered("random", sent);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle_ready();
    test_single_word();
    test_reset_midstream();
    test_random();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo_stream_out
